// File: rtl/vuprs_adc_pkg.sv
// vuprs_adc_pkg: shared FSM state encoding and frame constants for the ADC frame packer
package vuprs_adc_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t HDR  = 3'd1;
  localparam state_t CNT  = 3'd2;
  localparam state_t DATA = 3'd3;
  localparam state_t STAT = 3'd4;
  localparam int FRAME_WORDS = 19;
  localparam int N_CH = 8;
  localparam logic [15:0] HEADER_DEF = 16'hA5A5;
endpackage

// File: rtl/vuprs_adc_pair_sync.sv
// vuprs_adc_pair_sync: pairs ADC-A/ADC-B completion edges, detecting overruns and pair timeouts
//   sampling_a/b : ADC busy flags, falling edge = conversion set complete
//   cap          : top is capturing the pending pair this cycle
//   cap_req      : both ADCs have a pending completion
//   drop_pulse   : one frame dropped this cycle (overrun and/or timeout)
module vuprs_adc_pair_sync #(
  parameter int PAIR_TIMEOUT = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic sampling_a,
  input  logic sampling_b,
  input  logic cap,
  output logic cap_req,
  output logic drop_pulse
);
  localparam int TW = $clog2(PAIR_TIMEOUT + 1);
  logic prev_a, prev_b, pend_a, pend_b, fall_a, fall_b, ovr, tmo, keep;
  logic [TW-1:0] cnt;
  // A capture consumes the pending pair, so a coincident edge is never an overrun.
  always_comb begin
    fall_a = prev_a & ~sampling_a;
    fall_b = prev_b & ~sampling_b;
    ovr = ~cap & ((fall_a & pend_a) | (fall_b & pend_b));
    tmo = (pend_a ^ pend_b) & (cnt == TW'(PAIR_TIMEOUT - 1));
    keep = ~cap & ~ovr & ~tmo;
    cap_req = pend_a & pend_b;
    drop_pulse = ovr | tmo;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev_a <= 1'b1;
      prev_b <= 1'b1;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      cnt <= '0;
    end else begin
      prev_a <= sampling_a;
      prev_b <= sampling_b;
      pend_a <= (pend_a & keep) | fall_a;
      pend_b <= (pend_b & keep) | fall_b;
      cnt <= ((pend_a ^ pend_b) & keep & ~fall_a & ~fall_b) ? cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/vuprs_adc_frame_packer.sv
// vuprs_adc_frame_packer: packs paired ADC-A/ADC-B channel sets into 19-word framed streams
//   sampling_a/b, error_a/b, ch_a/b : ADC controller status and packed channels (ch1 in [15:0])
//   m_data/m_valid/m_ready/m_last   : 16-bit output stream, m_last on the status word
//   overflow/drop_cnt               : sticky drop flag and saturating drop count
module vuprs_adc_frame_packer import vuprs_adc_pkg::*; #(
  parameter logic [15:0] HEADER = HEADER_DEF,
  parameter int PAIR_TIMEOUT = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic sampling_a,
  input  logic sampling_b,
  input  logic error_a,
  input  logic error_b,
  input  logic [16*N_CH-1:0] ch_a,
  input  logic [16*N_CH-1:0] ch_b,
  output logic [15:0] m_data,
  output logic m_valid,
  input  logic m_ready,
  output logic m_last,
  output logic overflow,
  output logic [7:0] drop_cnt
);
  state_t state, nxt;
  logic [3:0] idx;
  logic [15:0] frame_cnt, sh_cnt, sh_stat;
  logic [32*N_CH-1:0] sh_ab;
  logic cap_req, drop_pulse, fire, ready, cap;
  vuprs_adc_pair_sync #(.PAIR_TIMEOUT(PAIR_TIMEOUT)) u_pair (
    .clk(clk),
    .rst(rst),
    .sampling_a(sampling_a),
    .sampling_b(sampling_b),
    .cap(cap),
    .cap_req(cap_req),
    .drop_pulse(drop_pulse)
  );
  // Outputs decode straight from registered state, so they hold while stalled.
  always_comb begin
    m_valid = state != IDLE;
    m_last = state == STAT;
    fire = m_valid & m_ready;
    ready = state == IDLE || (state == STAT && m_ready);
    cap = cap_req & ready;
    nxt = state == HDR ? CNT : state == CNT ? DATA : state == DATA ? (idx == 4'hF ? STAT : DATA) : IDLE;
    m_data = state == HDR ? HEADER : state == CNT ? sh_cnt : state == DATA ? sh_ab[{idx, 4'b0000} +: 16] : state == STAT ? sh_stat : 16'h0000;
  end
  // Status word is snapshotted at capture so it cannot change under backpressure.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      frame_cnt <= '0;
      sh_cnt <= '0;
      sh_stat <= '0;
      sh_ab <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop_pulse) begin
        overflow <= 1'b1;
        drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hFF};
      end
      if (cap) begin
        state <= HDR;
        sh_ab <= {ch_b, ch_a};
        sh_cnt <= frame_cnt;
        sh_stat <= {error_a, error_b, overflow, 5'b00000, drop_cnt};
        frame_cnt <= frame_cnt + 16'd1;
      end else if (fire) begin
        state <= nxt;
        if (state == DATA) idx <= idx + 4'd1;
      end
    end
endmodule

// File: tb/tb_vuprs_adc_frame_packer.sv
// tb_vuprs_adc_frame_packer: scoreboard bench for the ADC frame packer
module tb_vuprs_adc_frame_packer;
  import vuprs_adc_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic sa = 1'b1, sb = 1'b1, ea = 1'b0, eb = 1'b0, mr = 1'b1;
  logic [127:0] ca = '0, cb = '0;
  logic [15:0] md, s_data;
  logic mv, ml, ovf, s_valid, s_last, s_ovf, ssa = 1'b1, ssb = 1'b1;
  logic [7:0] dc, s_drop;
  int checks = 0, failures = 0, cyc = 0, first_v = -1, acc_cnt = 0, sat_seen = 0;
  bit bp = 0, last_acc = 0, post_v = 0, held_v = 0;
  logic [15:0] post_d;
  logic [16:0] held;
  logic [16:0] exp_q[$];

  always #10 clk = ~clk;

  vuprs_adc_frame_packer #(.HEADER(16'hA5A5), .PAIR_TIMEOUT(500)) dut (
    .clk(clk), .rst(rst), .sampling_a(sa), .sampling_b(sb), .error_a(ea), .error_b(eb),
    .ch_a(ca), .ch_b(cb), .m_data(md), .m_valid(mv), .m_ready(mr), .m_last(ml),
    .overflow(ovf), .drop_cnt(dc)
  );

  vuprs_adc_frame_packer #(.HEADER(16'hA5A5), .PAIR_TIMEOUT(8)) u_sat (
    .clk(clk), .rst(rst), .sampling_a(ssa), .sampling_b(ssb), .error_a(1'b0), .error_b(1'b0),
    .ch_a(ca), .ch_b(cb), .m_data(s_data), .m_valid(s_valid), .m_ready(1'b1), .m_last(s_last),
    .overflow(s_ovf), .drop_cnt(s_drop)
  );

  task tick();
    logic [16:0] e;
    @(negedge clk);
    if (held_v) begin
      checks++;
      if (!mv || {ml, md} !== held) begin
        failures++;
        $display("FAIL hold: got v=%0b data=%h last=%0b, want data=%h last=%0b", mv, md, ml, held[15:0], held[16]);
      end
    end
    held_v = mv && !mr;
    held = {ml, md};
    if (last_acc) begin
      post_v = mv;
      post_d = md;
    end
    last_acc = mv && mr && ml;
    if (mv && first_v < 0) first_v = cyc;
    if (s_valid || s_last || s_data != 16'h0) sat_seen++;
    if (mv && mr) begin
      acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stray_word: got data=%h last=%0b, want no word", md, ml);
      end else begin
        e = exp_q.pop_front();
        if ({ml, md} !== e) begin
          failures++;
          $display("FAIL word: got data=%h last=%0b, want data=%h last=%0b", md, ml, e[15:0], e[16]);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    mr = bp ? ~mr : 1'b1;
  endtask

  task push_frame(input logic [127:0] a, input logic [127:0] b, input logic [15:0] n, input logic [15:0] st);
    exp_q.push_back({1'b0, 16'hA5A5});
    exp_q.push_back({1'b0, n});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, i < 8 ? a[i*16 +: 16] : b[(i-8)*16 +: 16]});
    exp_q.push_back({1'b1, st});
  endtask

  task pulse_a();
    sa = 1'b0;
    tick();
    sa = 1'b1;
  endtask

  task pulse_b();
    sb = 1'b0;
    tick();
    sb = 1'b1;
  endtask

  task wait_acc(input int n);
    int k;
    k = 0;
    while (acc_cnt < n && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (acc_cnt < n) begin
      failures++;
      $display("FAIL wait_acc: got %0d accepted words, want %0d", acc_cnt, n);
    end
  endtask

  task drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d words outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (5) tick();
  endtask

  task do_reset();
    rst = 1'b0;
    exp_q.delete();
    sa = 1'b1; sb = 1'b1; ssa = 1'b1; ssb = 1'b1; ea = 1'b0; eb = 1'b0;
    bp = 0; mr = 1'b1; held_v = 0; last_acc = 0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    cyc = 0; first_v = -1; acc_cnt = 0;
  endtask

  task test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks += 6;
    if (mv !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, want 0", mv); end
    if (ml !== 1'b0) begin failures++; $display("FAIL rst_last: got %b, want 0", ml); end
    if (md !== 16'h0) begin failures++; $display("FAIL rst_data: got %h, want 0000", md); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b, want 0", ovf); end
    if (dc !== 8'h0) begin failures++; $display("FAIL rst_drop: got %0d, want 0", dc); end
    if (s_drop !== 8'h0) begin failures++; $display("FAIL rst_sat_drop: got %0d, want 0", s_drop); end
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (mv !== 1'b0) begin failures++; $display("FAIL rst_release_valid: got %b, want 0", mv); end
  endtask

  task test_pairing();
    logic [127:0] a0;
    do_reset();
    ca = {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    cb = {16'hB008, 16'hB007, 16'hB006, 16'hB005, 16'hB004, 16'hB003, 16'hB002, 16'hB001};
    a0 = ca;
    while (cyc < 10) tick();
    pulse_a();
    tick();
    push_frame(a0, cb, 16'h0000, 16'h0000);
    pulse_b();
    repeat (2) tick();
    ca = ~a0;
    drain();
    ca = a0;
    checks++;
    if (first_v != 14) begin failures++; $display("FAIL header_cycle: got %0d, want 14", first_v); end
  endtask

  task test_backpressure();
    bp = 1;
    pulse_a();
    tick();
    push_frame(ca, cb, 16'h0001, 16'h0000);
    pulse_b();
    drain();
    bp = 0;
    tick();
  endtask

  task test_back_to_back();
    logic [127:0] a2;
    do_reset();
    pulse_a();
    pulse_b();
    push_frame(ca, cb, 16'h0000, 16'h0000);
    wait_acc(5);
    a2 = {16'hC008, 16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001};
    ca = a2;
    ea = 1'b1;
    pulse_a();
    pulse_b();
    push_frame(a2, cb, 16'h0001, 16'h8000);
    wait_acc(19);
    tick();
    checks += 2;
    if (post_v !== 1'b1) begin failures++; $display("FAIL b2b_gap_valid: got %b, want 1", post_v); end
    if (post_d !== 16'hA5A5) begin failures++; $display("FAIL b2b_gap_header: got %h, want a5a5", post_d); end
    drain();
    ea = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_overflow: got %b, want 0", ovf); end
  endtask

  task test_timeout();
    do_reset();
    pulse_a();
    repeat (490) tick();
    checks += 2;
    if (dc !== 8'd0) begin failures++; $display("FAIL tmo_early_drop: got %0d, want 0", dc); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL tmo_early_overflow: got %b, want 0", ovf); end
    repeat (20) tick();
    checks += 3;
    if (dc !== 8'd1) begin failures++; $display("FAIL tmo_drop: got %0d, want 1", dc); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL tmo_overflow: got %b, want 1", ovf); end
    if (first_v >= 0) begin failures++; $display("FAIL tmo_no_frame: got valid at cycle %0d, want none", first_v); end
  endtask

  task test_overrun();
    do_reset();
    ea = 1'b1;
    pulse_a();
    repeat (2) tick();
    pulse_a();
    repeat (2) tick();
    pulse_a();
    tick();
    checks += 2;
    if (dc !== 8'd2) begin failures++; $display("FAIL ovr_drop: got %0d, want 2", dc); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL ovr_overflow: got %b, want 1", ovf); end
    push_frame(ca, cb, 16'h0000, 16'hA002);
    pulse_b();
    drain();
    ea = 1'b0;
    checks++;
    if (dc !== 8'd2) begin failures++; $display("FAIL ovr_drop_after: got %0d, want 2", dc); end
  endtask

  task test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ssa = 1'b0;
      tick();
      ssa = 1'b1;
      repeat (11) tick();
      if (i == 99) begin
        checks++;
        if (s_drop !== 8'd100) begin failures++; $display("FAIL sat_mid: got %0d, want 100", s_drop); end
      end
    end
    checks += 3;
    if (s_drop !== 8'd255) begin failures++; $display("FAIL sat_drop: got %0d, want 255", s_drop); end
    if (s_ovf !== 1'b1) begin failures++; $display("FAIL sat_overflow: got %b, want 1", s_ovf); end
    if (sat_seen != 0) begin failures++; $display("FAIL sat_no_frame: got %0d active cycles, want 0", sat_seen); end
  endtask

  task test_reset_mid_frame();
    do_reset();
    pulse_a();
    pulse_b();
    push_frame(ca, cb, 16'h0000, 16'h0000);
    wait_acc(7);
    checks++;
    if (md !== ca[95:80]) begin failures++; $display("FAIL mid_data5: got %h, want %h", md, ca[95:80]); end
    rst = 1'b0;
    #1;
    checks += 2;
    if (mv !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b, want 0", mv); end
    if (ml !== 1'b0) begin failures++; $display("FAIL mid_last: got %b, want 0", ml); end
    exp_q.delete();
    held_v = 0;
    tick();
    rst = 1'b1;
    tick();
    first_v = -1;
    pulse_a();
    pulse_b();
    push_frame(ca, cb, 16'h0000, 16'h0000);
    drain();
  endtask

  initial begin
    test_reset();
    test_pairing();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_saturation();
    test_reset_mid_frame();
    checks++;
    if (FRAME_WORDS != 19 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue: got %0d words outstanding, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vuprs_adc_frame_packer.md
VUPRS_ADC_FRAME_PACKER -- requirements
Module: vuprs_adc_frame_packer

Interface
REQ-001 The block SHALL have parameter HEADER, default 16'hA5A5: first word of every frame.
REQ-002 The block SHALL have parameter PAIR_TIMEOUT, default 500: max clk cycles between ADC-A and ADC-B completions.
REQ-003 The block SHALL have port clk, input, 1: system clock, 50 MHz.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports sampling_a and sampling_b, input, 1 each: ADC controller busy flag; a falling edge means a conversion set is complete.
REQ-006 The block SHALL have ports error_a and error_b, input, 1 each: ADC controller error flags.
REQ-007 The block SHALL have ports ch_a and ch_b, input, 128 each: channels 1..8 packed, with ch1 in [15:0].
REQ-008 The block SHALL have port m_data, output, 16: stream word.
REQ-009 The block SHALL have port m_valid, output, 1: stream word valid.
REQ-010 The block SHALL have port m_ready, input, 1: downstream accepts the word.
REQ-011 The block SHALL have port m_last, output, 1: marks the final word of a frame.
REQ-012 The block SHALL have port overflow, output, 1: sticky flag, set when any frame is dropped.
REQ-013 The block SHALL have port drop_cnt, output, 8: count of dropped frames, saturating.

Function
REQ-014 The block SHALL detect falling edges of sampling_a and sampling_b using a registered previous value; each edge sets pend_a or pend_b respectively.
REQ-015 When pend_a, pend_b and FSM-ready all hold, the block SHALL, in a single cycle:
- snapshot ch_a, ch_b, error_a and error_b into shadow registers;
- clear both pend flags;
- enter state HDR.
REQ-016 FSM-ready SHALL be true in IDLE, and in STAT on the cycle m_valid&&m_ready holds, so that frames can run back-to-back with no gap.
REQ-017 Each frame SHALL be 19 words, emitted in this order:
- HDR: HEADER;
- CNT: frame_cnt;
- DATA: 16 words, A ch1..ch8 then B ch1..ch8;
- STAT: {error_a, error_b, overflow, 5'b0, drop_cnt}.
REQ-018 m_last SHALL be 1 only in STAT.
REQ-019 FSM states SHALL be IDLE, HDR, CNT, DATA and STAT. A state SHALL advance only on m_valid&&m_ready. DATA SHALL use a 4-bit index that advances 0..15 and leaves DATA after index 15.
REQ-020 m_valid SHALL be 1 in every state except IDLE. m_data and m_last SHALL stay stable while m_valid&&!m_ready.
REQ-021 The first header SHALL appear on m_data with m_valid=1 on the cycle after capture, i.e. 2 cycles after the later sampling falling edge.
REQ-022 frame_cnt SHALL be 16 bits, increment on each capture, and wrap from 16'hFFFF to 0. The CNT word SHALL carry the pre-increment value, so the first frame after reset carries 0.
REQ-023 An overrun SHALL occur on a falling edge of an ADC whose pend flag is already set. On overrun:
- the old pending pair is discarded;
- the other ADC's pend flag is cleared;
- pend for the new edge is set;
- drop_cnt increments;
- overflow is set.
REQ-024 The timeout counter SHALL run while exactly one pend flag is set. When it reaches PAIR_TIMEOUT, the block SHALL clear that pend flag, increment drop_cnt and set overflow.
REQ-025 When edges of both ADCs arrive in the same cycle, both pend flags SHALL be set with no timeout activity.
REQ-026 drop_cnt SHALL saturate at 255.
REQ-027 When an overrun and a timeout occur in the same cycle, drop_cnt SHALL increment by 1 only.
REQ-028 When an edge arrives in the same cycle as a capture, the capture SHALL consume the existing pend flags, and the new edge SHALL set a new pend flag for the next frame.

Reset
REQ-029 Asserting rst (low) SHALL asynchronously set:
- FSM to IDLE;
- m_valid=0, m_last=0, m_data=0;
- overflow=0, drop_cnt=0, frame_cnt=0;
- pend flags and timeout counter cleared;
- shadow registers cleared.
REQ-030 The edge-detect registers SHALL reset to 1, so that a low sampling input at reset release creates no edge.
REQ-031 A reset asserted in the middle of a frame SHALL abort the frame with no m_last. The first frame after release SHALL start with HEADER and frame_cnt 0.

Structure
REQ-032 The shared package vuprs_adc_pkg SHALL hold the FSM state typedef, FRAME_WORDS=19, N_CH=8 and the default HEADER.
REQ-033 The block SHALL contain one sub-module, vuprs_adc_pair_sync, holding the edge detect, pend flags, timeout counter and overrun logic. It SHALL output cap_req and drop_pulse.
REQ-034 The FSM, shadow registers and counters SHALL reside in the top module.

Verification
REQ-035 The bench SHALL cover:
- Pairing: sampling_a falls at cycle 10, sampling_b at cycle 12, ch_a ch1=16'h1111, m_ready=1 -> HEADER at cycle 14, then 0000, 1111 … , m_last on the 19th word, STAT=16'h0000.
- Backpressure: m_ready toggled every cycle -> m_data holds while not ready; the word sequence is identical to the m_ready=1 case.
- Timeout: only sampling_a falls, PAIR_TIMEOUT=500 -> drop_cnt=1 and overflow=1 after 500 cycles; no frame emitted.
- Back-to-back: a second pair completes during DATA -> the second header follows m_last with no idle cycle; its CNT word is 0001.
- Overrun/saturation: three sampling_a edges without sampling_b -> drop_cnt=2; 300 timeouts -> drop_cnt stays at 255.
- Reset mid-frame: rst asserted during DATA index 5 -> m_valid=0 immediately; the next frame starts with HEADER, then 0000.
